// File: rtl/enclave_pkg.sv
// Shared opcode layout, op/state encodings and default widths for the enclave sequencer.
// Declarations only: no logic, no latency, no flow control.
package enclave_pkg;

  localparam int DEF_WB_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_ADDR_WIDTH = 10;

  // Opcode word layout: [3:0] op, [13:4] base address, [23:14] word count.
  localparam int OP_LSB   = 0;
  localparam int OP_W     = 4;
  localparam int BASE_LSB = 4;
  localparam int BASE_W   = 10;
  localparam int CNT_LSB  = 14;
  localparam int CNT_W    = 10;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 4'd0,
    OP_LOAD   = 4'd1,
    OP_RUN    = 4'd2,
    OP_READ   = 4'd3,
    OP_CLRERR = 4'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/enclave_beat_packer.sv
// Packs host beats LSB-first into one wide word and unpacks a wide word back into beats.
// Latency: word_vld one cycle after the last beat; pop_dat follows the beat counter combinationally.
// Backpressure: none internally; pops are only issued by the caller while its output is valid.
module enclave_beat_packer
  import enclave_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WB_WIDTH   = DEF_WB_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  beat_vld,
  input  logic [WB_WIDTH-1:0]   beat_dat,
  output logic                  word_vld,
  output logic [DATA_WIDTH-1:0] word_dat,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_dat,
  input  logic                  pop,
  output logic [WB_WIDTH-1:0]   pop_dat,
  output logic                  last_pop
);

  localparam int BEATS = DATA_WIDTH / WB_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  // One counter and one buffer serve both directions; the FSM never packs and unpacks at once.
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] packed_word;
  logic                  at_last;

  assign at_last  = (cnt_q == LAST);
  assign last_pop = pop && at_last;

  always_comb begin
    packed_word = shift_q;
    pop_dat     = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CW'(k)) begin
        packed_word[k*WB_WIDTH +: WB_WIDTH] = beat_dat;
        pop_dat = shift_q[k*WB_WIDTH +: WB_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      word_dat <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      if (clear) begin
        cnt_q   <= '0;
        shift_q <= '0;
      end else if (load) begin
        cnt_q   <= '0;
        shift_q <= load_dat;
      end else if (beat_vld || pop) begin
        cnt_q <= at_last ? '0 : cnt_q + 1'b1;
        if (beat_vld) begin
          shift_q <= packed_word;
          if (at_last) begin
            word_vld <= 1'b1;
            word_dat <= packed_word;
          end
        end
      end
    end
  end

endmodule

// File: rtl/enclave_sequencer.sv
// Host command sequencer: decodes opcodes, packs beats into SRAM words, launches the core, streams results back.
// Latency: opcode acts next cycle; mem_we 1 cycle after the 4th beat; a read word reaches the host 2 cycles after its address.
// Backpressure: each result beat holds until out_pop; ENCLAVE_SEQ_TIMEOUT_EN adds a 16-bit RUN watchdog.
module enclave_sequencer
  import enclave_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WB_WIDTH   = DEF_WB_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  config_en,
  input  logic                  input_ready,
  input  logic [WB_WIDTH-1:0]   wishbone_data,
  input  logic                  out_pop,
  output logic                  output_ready,
  output logic [WB_WIDTH-1:0]   wishbone_output,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  core_start,
  output logic [ADDR_WIDTH-1:0] core_base,
  output logic [ADDR_WIDTH-1:0] core_len,
  input  logic                  core_done,
  output logic                  busy,
  output logic                  err
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      remain_q, remain_d;
  logic                  err_q, err_d;
  logic                  start_q, start_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;

  logic [OP_W-1:0]       cfg_op;
  logic [ADDR_WIDTH-1:0] cfg_base;
  logic [CNT_W-1:0]      cfg_cnt;

  logic pack_clear, pack_beat, unpack_load, drain_pop;
  logic word_vld, last_pop;
  logic [WB_WIDTH-1:0] pop_dat;
  logic err_set, err_clr;
  logic run_timeout;

  assign cfg_op   = wishbone_data[OP_LSB +: OP_W];
  assign cfg_base = ADDR_WIDTH'(wishbone_data[BASE_LSB +: BASE_W]);
  assign cfg_cnt  = wishbone_data[CNT_LSB +: CNT_W];

`ifdef ENCLAVE_SEQ_TIMEOUT_EN
  // wd_q is the index of the current RUN cycle; the 65535th cycle is the last one allowed.
  localparam logic [15:0] WD_LAST = 16'hFFFE;
  logic [15:0] wd_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_q != ST_RUN) wd_q <= '0;
    else                               wd_q <= wd_q + 16'd1;
  end

  assign run_timeout = (wd_q == WD_LAST);
`else
  assign run_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    err_d       = err_q;
    start_d     = 1'b0;
    base_d      = base_q;
    len_d       = len_q;
    pack_clear  = 1'b0;
    pack_beat   = 1'b0;
    unpack_load = 1'b0;
    drain_pop   = 1'b0;
    err_clr     = 1'b0;
    err_set     = (config_en && state_q != ST_IDLE) || (input_ready && state_q != ST_LOAD);

    case (state_q)
      ST_IDLE: begin
        if (config_en) begin
          case (cfg_op)
            OP_NOP:    ;
            OP_CLRERR: err_clr = 1'b1;
            OP_LOAD, OP_RUN, OP_READ: begin
              if (cfg_cnt == '0) begin
                err_set = 1'b1;
              end else begin
                addr_d   = cfg_base;
                remain_d = cfg_cnt;
                if (cfg_op == OP_LOAD) begin
                  state_d    = ST_LOAD;
                  pack_clear = 1'b1;
                end else if (cfg_op == OP_RUN) begin
                  state_d = ST_RUN;
                  start_d = 1'b1;
                  base_d  = cfg_base;
                  len_d   = ADDR_WIDTH'(cfg_cnt);
                end else begin
                  state_d = ST_RD_ADDR;
                end
              end
            end
            default:   err_set = 1'b1;
          endcase
        end
      end
      ST_LOAD: begin
        pack_beat = input_ready;
        // The address advances only after the write cycle so mem_addr is stable during mem_we.
        if (word_vld) begin
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (core_done) begin
          state_d = ST_IDLE;
        end else if (run_timeout) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_ADDR: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        unpack_load = 1'b1;
        state_d     = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_pop = out_pop;
        if (last_pop) begin
          remain_d = remain_q - 1'b1;
          if (remain_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_RD_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A simultaneous protocol error wins over CLRERR.
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      err_q    <= err_d;
      start_q  <= start_d;
      base_q   <= base_d;
      len_q    <= len_d;
    end
  end

  enclave_beat_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .WB_WIDTH  (WB_WIDTH)
  ) u_packer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (pack_clear),
    .beat_vld(pack_beat),
    .beat_dat(wishbone_data),
    .word_vld(word_vld),
    .word_dat(mem_wdata),
    .load    (unpack_load),
    .load_dat(mem_rdata),
    .pop     (drain_pop),
    .pop_dat (pop_dat),
    .last_pop(last_pop)
  );

  assign output_ready    = (state_q == ST_DRAIN);
  assign wishbone_output = output_ready ? pop_dat : '0;
  assign mem_we          = word_vld;
  assign mem_addr        = addr_q;
  assign core_start      = start_q;
  assign core_base       = base_q;
  assign core_len        = len_q;
  assign busy            = (state_q != ST_IDLE);
  assign err             = err_q;

endmodule

// File: tb/tb_enclave_sequencer.sv
// Scoreboard bench for enclave_sequencer: expected SRAM writes, core starts and result beats are queued
// by the stimulus and consumed by independent monitors; host pops are issued with random spacing.
module tb_enclave_sequencer;
  import enclave_pkg::*;

  localparam int AW = 10;
  localparam int DW = 128;
  localparam int WW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
  } st_t;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          config_en = 1'b0;
  logic          input_ready = 1'b0;
  logic [WW-1:0] wishbone_data = '0;
  logic          out_pop = 1'b0;
  logic          core_done = 1'b0;
  logic          output_ready;
  logic [WW-1:0] wishbone_output;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          core_start;
  logic [AW-1:0] core_base;
  logic [AW-1:0] core_len;
  logic          busy;
  logic          err;

  logic [DW-1:0] sram    [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  wr_t           exp_wr[$];
  st_t           exp_start[$];
  logic [WW-1:0] exp_beats[$];
  st_t           loaded[$];

  int   checks = 0;
  int   errors = 0;
  wr_t  mon_wr;
  st_t  mon_st;
  logic start_prev = 1'b0;
  int   pop_gap = 0;

  enclave_sequencer dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .config_en      (config_en),
    .input_ready    (input_ready),
    .wishbone_data  (wishbone_data),
    .out_pop        (out_pop),
    .output_ready   (output_ready),
    .wishbone_output(wishbone_output),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .core_start     (core_start),
    .core_base      (core_base),
    .core_len       (core_len),
    .core_done      (core_done),
    .busy           (busy),
    .err            (err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Synchronous SRAM with one-cycle read latency.
  always @(posedge wb_clk_i) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    mem_rdata <= sram[mem_addr];
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor.
  always @(negedge wb_clk_i) begin
    if (mem_we) begin
      if (exp_wr.size() == 0) begin
        check("mem_we unexpected", mem_we, 1'b0);
      end else begin
        mon_wr = exp_wr.pop_front();
        check("mem_addr", mem_addr, mon_wr.addr);
        check("mem_wdata", mem_wdata, mon_wr.data);
      end
    end
  end

  // Core-start monitor.
  always @(negedge wb_clk_i) begin
    if (core_start) begin
      check("core_start one cycle", start_prev, 1'b0);
      if (exp_start.size() == 0) begin
        check("core_start unexpected", core_start, 1'b0);
      end else begin
        mon_st = exp_start.pop_front();
        check("core_base", core_base, mon_st.base);
        check("core_len", core_len, mon_st.len);
      end
    end
    start_prev = core_start;
  end

  // Host-side output monitor: consumes beats with 0-5 idle cycles between pops.
  initial begin : popper
    forever begin
      @(negedge wb_clk_i);
      #1;
      out_pop = 1'b0;
      if (output_ready) begin
        if (exp_beats.size() == 0) begin
          check("output_ready unexpected", output_ready, 1'b0);
          out_pop = 1'b1;
        end else if (pop_gap > 0) begin
          check("beat held", wishbone_output, exp_beats[0]);
          pop_gap--;
        end else begin
          check("beat", wishbone_output, exp_beats.pop_front());
          out_pop = 1'b1;
          pop_gap = $urandom_range(0, 5);
        end
      end
    end
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Stimulus tasks are entered on a negedge and return one negedge later.
  task automatic send_cfg(input logic [3:0] op, input logic [9:0] base, input logic [9:0] cnt);
    wishbone_data = {8'h00, cnt, base, op};
    config_en = 1'b1;
    @(negedge wb_clk_i);
    config_en = 1'b0;
  endtask

  task automatic send_beat(input logic [WW-1:0] d);
    wishbone_data = d;
    input_ready = 1'b1;
    @(negedge wb_clk_i);
    input_ready = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge wb_clk_i);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] base, input int i);
    return AW'((int'(base) + i) % 1024);
  endfunction

  task automatic expect_word(input logic [AW-1:0] a, input logic [DW-1:0] w);
    exp_wr.push_back({a, w});
    ref_mem[a] = w;
  endtask

  // Loads n words of random beats, LSB beat first.
  task automatic do_load(input logic [AW-1:0] base, input int n, input int max_gap);
    logic [DW-1:0] w;
    logic [WW-1:0] b;
    send_cfg(OP_LOAD, base, 10'(n));
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int k = 0; k < DW / WW; k++) begin
        b = $urandom;
        w[k*WW +: WW] = b;
        if (k == DW / WW - 1) expect_word(wrap_addr(base, i), w);
        send_beat(b);
        idle_cycles($urandom_range(0, max_gap));
      end
    end
    wait_idle(20, "idle after load");
    loaded.push_back({base, AW'(n)});
  endtask

  task automatic do_read(input logic [AW-1:0] base, input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = ref_mem[wrap_addr(base, i)];
      for (int k = 0; k < DW / WW; k++) exp_beats.push_back(w[k*WW +: WW]);
    end
    send_cfg(OP_READ, base, 10'(n));
    wait_idle(n * 40, "idle after read");
    check("read beats all delivered", exp_beats.size(), 0);
  endtask

  task automatic do_run(input logic [AW-1:0] base, input logic [AW-1:0] len, input int delay);
    exp_start.push_back({base, len});
    send_cfg(OP_RUN, base, len);
    check("busy in run", busy, 1'b1);
    idle_cycles(delay);
    core_done = 1'b1;
    @(negedge wb_clk_i);
    core_done = 1'b0;
    check("idle after core_done", busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " output_ready"}, output_ready, 1'b0);
    check({tag, " wishbone_output"}, wishbone_output, '0);
    check({tag, " mem_we"}, mem_we, 1'b0);
    check({tag, " mem_addr"}, mem_addr, '0);
    check({tag, " mem_wdata"}, mem_wdata, '0);
    check({tag, " core_start"}, core_start, 1'b0);
    check({tag, " core_base"}, core_base, '0);
    check({tag, " core_len"}, core_len, '0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " err"}, err, 1'b0);
  endtask

  logic [DW-1:0] w;
  logic [WW-1:0] b;
  st_t           r;
  int            n;

  initial begin : stimulus
    repeat (3) @(negedge wb_clk_i);
    check_all_zero("reset");
    wb_rst_i = 1'b0;
    idle_cycles(2);

    // Single-word load at 5 with fixed beats.
    send_cfg(OP_LOAD, 10'd5, 10'd1);
    expect_word(10'd5, 128'h44444444_33333333_22222222_11111111);
    send_beat(32'h11111111);
    send_beat(32'h22222222);
    send_beat(32'h33333333);
    send_beat(32'h44444444);
    check("mem_we after 4th beat", mem_we, 1'b1);
    check("busy during write", busy, 1'b1);
    @(negedge wb_clk_i);
    check("busy drops after write", busy, 1'b0);
    loaded.push_back({10'd5, 10'd1});

    do_run(10'd5, 10'd3, 20);

    // Wrapping load and read: addresses 1023 then 0.
    do_load(10'd1023, 2, 1);
    do_read(10'd1023, 2);
    do_read(10'd5, 1);

    // Protocol errors.
    send_cfg(4'd7, 10'd0, 10'd1);
    check("illegal op sets err", err, 1'b1);
    check("illegal op stays idle", busy, 1'b0);
    send_cfg(OP_CLRERR, 10'd0, 10'd1);
    check("clrerr clears err", err, 1'b0);
    send_beat(32'hDEADBEEF);
    check("beat in idle sets err", err, 1'b1);
    idle_cycles(3);
    check("beat in idle stays idle", busy, 1'b0);
    send_cfg(OP_CLRERR, 10'd0, 10'd1);
    check("clrerr clears err 2", err, 1'b0);
    send_cfg(OP_LOAD, 10'd3, 10'd0);
    check("count zero sets err", err, 1'b1);
    check("count zero stays idle", busy, 1'b0);
    send_cfg(OP_NOP, 10'd0, 10'd1);
    check("nop stays idle", busy, 1'b0);
    send_cfg(OP_CLRERR, 10'd0, 10'd1);
    core_done = 1'b1;
    @(negedge wb_clk_i);
    core_done = 1'b0;
    check("core_done in idle ignored", busy, 1'b0);
    check("core_done in idle no err", err, 1'b0);

    // Opcode during LOAD is ignored but flagged.
    send_cfg(OP_LOAD, 10'd50, 10'd1);
    w = {$urandom, $urandom, $urandom, $urandom};
    expect_word(10'd50, w);
    send_beat(w[31:0]);
    send_beat(w[63:32]);
    send_cfg(OP_READ, 10'd50, 10'd1);
    check("cfg in load sets err", err, 1'b1);
    check("cfg in load stays busy", busy, 1'b1);
    send_beat(w[95:64]);
    send_beat(w[127:96]);
    wait_idle(5, "idle after interrupted load");
    loaded.push_back({10'd50, 10'd1});
    send_cfg(OP_CLRERR, 10'd0, 10'd1);

    // Opcode and beat in the same idle cycle: opcode wins, beat dropped.
    wishbone_data = {8'h00, 10'd1, 10'd60, OP_LOAD};
    config_en = 1'b1;
    input_ready = 1'b1;
    @(negedge wb_clk_i);
    config_en = 1'b0;
    input_ready = 1'b0;
    check("cfg+beat sets err", err, 1'b1);
    check("cfg+beat load accepted", busy, 1'b1);
    w = {$urandom, $urandom, $urandom, $urandom};
    expect_word(10'd60, w);
    for (int k = 0; k < 4; k++) send_beat(w[k*WW +: WW]);
    wait_idle(5, "idle after cfg+beat load");
    do_read(10'd60, 1);
    send_cfg(OP_CLRERR, 10'd0, 10'd1);

    // Reset after two beats discards the partial word.
    send_cfg(OP_LOAD, 10'd9, 10'd1);
    send_beat(32'hAAAA0001);
    send_beat(32'hAAAA0002);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check_all_zero("mid-load reset");
    wb_rst_i = 1'b0;
    idle_cycles(3);
    do_load(10'd9, 1, 0);
    do_read(10'd9, 1);

    // Randomised mix of loads, reads and runs.
    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 2))
        0: do_load(AW'($urandom), $urandom_range(1, 3), 2);
        1: begin
          r = loaded[$urandom_range(0, loaded.size() - 1)];
          do_read(r.base, int'(r.len));
        end
        default: do_run(AW'($urandom), AW'($urandom_range(1, 1023)), $urandom_range(0, 10));
      endcase
    end

    // RUN without core_done.
    exp_start.push_back({10'd1, 10'd1});
    send_cfg(OP_RUN, 10'd1, 10'd1);
`ifdef ENCLAVE_SEQ_TIMEOUT_EN
    n = 0;
    while (busy && n < 70000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("timeout returns idle", busy, 1'b0);
    check("timeout sets err", err, 1'b1);
    check("timeout cycle count", n, 65535);
    core_done = 1'b1;
    @(negedge wb_clk_i);
    core_done = 1'b0;
    check("late core_done ignored", busy, 1'b0);
    send_cfg(OP_CLRERR, 10'd0, 10'd1);
`else
    idle_cycles(70000);
    check("run still busy at 70000", busy, 1'b1);
    check("run no err without watchdog", err, 1'b0);
    core_done = 1'b1;
    @(negedge wb_clk_i);
    core_done = 1'b0;
    check("idle after late core_done", busy, 1'b0);
`endif

    idle_cycles(5);
    check("pending writes", exp_wr.size(), 0);
    check("pending starts", exp_start.size(), 0);
    check("pending beats", exp_beats.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enclave_sequencer.md
Name: enclave_sequencer

Overview:
- Command sequencer between the wishbone_ctl slave and the LWE compute datapath.
- Decodes opcode words written to the opcode address (config_en).
- Packs 32-bit host beats into 128-bit operand words and writes them to the operand SRAM.
- Launches the compute core, then streams 128-bit results back to the host as 32-bit beats through wishbone_output/output_ready.

Parameters:
- DATA_WIDTH, 128, SRAM/core word width; must be a multiple of WB_WIDTH.
- WB_WIDTH, 32, host beat width.
- ADDR_WIDTH, 10, SRAM address width (DEPTH = 1024).
- BEATS, DATA_WIDTH/WB_WIDTH = 4, beats per SRAM word (derived localparam).

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- config_en  in  1  1-cycle pulse: wishbone_data holds an opcode word.
- input_ready  in  1  1-cycle pulse: wishbone_data holds a data beat.
- wishbone_data  in  32  opcode word or data beat.
- out_pop  in  1  1-cycle pulse: host consumed the current wishbone_output.
- output_ready  out  1  wishbone_output is valid.
- wishbone_output  out  32  result beat.
- mem_we  out  1  SRAM write strobe.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_wdata  out  DATA_WIDTH  SRAM write data.
- mem_rdata  in  DATA_WIDTH  SRAM read data; valid 1 cycle after the address is presented.
- core_start  out  1  1-cycle start pulse to the compute core.
- core_base  out  ADDR_WIDTH  operand base address for the core.
- core_len  out  ADDR_WIDTH  operand word count for the core.
- core_done  in  1  1-cycle completion pulse from the core.
- busy  out  1  state != IDLE.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset:
  - All outputs 0; state = IDLE; beat counter, address register and pack buffer cleared.
  - Reset mid-operation aborts at once; a partial pack buffer is discarded and no write is issued.
- Opcode word fields:
  - [3:0] op: 0 NOP, 1 LOAD, 2 RUN, 3 READ, 4 CLRERR.
  - [13:4] base address.
  - [23:14] count in 128-bit words; count = 0 is illegal.
  - Other op values are illegal.
- States: IDLE, LOAD, RUN, RD_ADDR, RD_WAIT, DRAIN.
- IDLE:
  - config_en decodes next cycle.
  - NOP stays in IDLE. CLRERR clears err. Illegal op or count = 0 sets err and stays in IDLE.
  - LOAD -> LOAD; RUN -> RUN with core_start pulsed for exactly 1 cycle and core_base/core_len latched; READ -> RD_ADDR.
- LOAD:
  - Each input_ready beat fills slice [32k+31:32k], with k = beat index 0..3, first beat in the LSBs.
  - On the cycle after the 4th beat: mem_we = 1 for 1 cycle at the current address; address increments; words-remaining decrements.
  - After the last word is written -> IDLE.
- RUN: wait for core_done, then -> IDLE. A core_done pulse outside RUN is ignored.
- Read path:
  - RD_ADDR drives mem_addr; RD_WAIT captures mem_rdata next cycle -> DRAIN.
  - DRAIN: output_ready = 1 with slice k on wishbone_output; each out_pop advances k.
  - After the 4th pop: either the next word (RD_ADDR, address + 1) or, after the last word, output_ready drops in the same cycle -> IDLE.
  - out_pop while output_ready = 0 is ignored.
- Address arithmetic wraps modulo 2^ADDR_WIDTH (base 1023, count 2 -> addresses 1023, 0).
- Protocol errors:
  - config_en outside IDLE: ignored, err set.
  - input_ready outside LOAD: beat dropped, err set.
  - config_en and input_ready in the same IDLE cycle: opcode accepted, beat dropped, err set.
- err stays set until CLRERR or reset.

Optional Feature:
- Macro: ENCLAVE_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles in RUN.
  - If core_done has not arrived after 65535 cycles: err set, -> IDLE.
  - A core_done arriving later is ignored.
- Undefined: RUN waits indefinitely; no counter is synthesized.

Decomposition:
- Shared package enclave_pkg:
  - op enum (NOP/LOAD/RUN/READ/CLRERR).
  - State enum.
  - Opcode field bit positions.
  - WB_WIDTH/DATA_WIDTH/ADDR_WIDTH defaults.
- One natural sub-module, enclave_beat_packer: 32->128 pack and 128->32 unpack with beat counter. Everything else stays in one FSM.

Test Plan:
- LOAD, base 5, count 1, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> one mem_we at addr 5, data 0x44444444_33333333_22222222_11111111; busy drops the next cycle.
- RUN, base 5, count 3 -> core_start pulses 1 cycle with core_base 5, core_len 3; core_done after 20 cycles -> IDLE, busy = 0.
- READ, base 1023, count 2, SRAM preloaded -> 8 beats LSB-first from addr 1023 then addr 0; output_ready holds between pops; no beat lost with pops spaced 0-5 cycles.
- Protocol errors:
  - op = 7 -> err = 1 and state stays IDLE.
  - input_ready in IDLE -> err = 1 and no mem_we.
  - CLRERR -> err = 0.
- Wishbone reset mid-LOAD after 2 beats -> no mem_we, all outputs 0; a fresh LOAD works normally.
- With ENCLAVE_SEQ_TIMEOUT_EN defined: RUN with core_done never asserted -> err = 1 and IDLE after 65535 cycles. Without the macro: still busy at 70000 cycles.
